// File: rtl/writeback_unit.sv
// Writeback stage of the Y86-64 pipeline: destination selection, the 15x64
// register file (E and M write ports, two decode read ports), the processor
// status FSM and the W-stage forwarding outputs.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_unit #(
    parameter bit          BYPASS   = 1'b1,
    parameter logic [63:0] RSP_INIT = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode_w,
    input  logic [3:0]  ifun_w,
    input  logic        cnd_w,
    input  logic [3:0]  regA_w,
    input  logic [3:0]  regB_w,
    input  logic [63:0] valE_w,
    input  logic [63:0] valM_w,
    input  logic [2:0]  w_stat,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA_d,
    output logic [63:0] valB_d,
    output logic [3:0]  w_dstE,
    output logic [3:0]  w_dstM,
    output logic [63:0] w_valE,
    output logic [63:0] w_valM,
    output logic [2:0]  cpu_stat,
    output logic        halted,
    output logic [63:0] retired
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state, stateNext;
    logic [2:0]  cpuStatNext;
    logic        wrEn;
    logic [3:0]  dstE, dstM;
    logic [63:0] regFile [15];

    // function code only travels with the bundle; nothing here decodes it
    logic unusedIfun;
    assign unusedIfun = ^ifun_w;

    // Raw E destination from the instruction code
    always_comb begin
        dstE = RNONE;
        case (icode_w)
            4'h2:                      dstE = cnd_w ? regB_w : RNONE;
            4'h3, 4'h6:                dstE = regB_w;
            4'h8, 4'h9, 4'hA, 4'hB:    dstE = RRSP;
            default:                   dstE = RNONE;
        endcase
    end

    // Raw M destination: only mrmovq and popq load a register from memory
    always_comb begin
        dstM = RNONE;
        if (icode_w == 4'h5 || icode_w == 4'hB) dstM = regA_w;
    end

    // State register: FSM state and architectural status
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            cpu_stat <= STAT_AOK;
        end else begin
            state    <= stateNext;
            cpu_stat <= cpuStatNext;
        end
    end

    // Next-state: any non-AOK, non-bubble status in RUN stops the machine
    always_comb begin
        stateNext   = state;
        cpuStatNext = cpu_stat;
        if (state == RUN) begin
            case (w_stat)
                3'd0, 3'd1: ;
                3'd2, 3'd3, 3'd4: begin
                    stateNext   = HALTED;
                    cpuStatNext = w_stat;
                end
                default: begin
                    // undefined status codes are treated as bad instructions
                    stateNext   = HALTED;
                    cpuStatNext = STAT_INS;
                end
            endcase
        end
    end

    // FSM outputs: write permission and halt flag
    always_comb begin
        wrEn   = (state == RUN) && (w_stat == STAT_AOK);
        halted = (state == HALTED);
    end

    // Forwarding outputs; suppressed destinations read back as F
    always_comb begin
        w_dstE = wrEn ? dstE : RNONE;
        w_dstM = wrEn ? dstM : RNONE;
        w_valE = valE_w;
        w_valM = valM_w;
    end

    // Register file writes; M port is applied last so it wins on dstE==dstM
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++)
                regFile[i] <= (i == 4) ? RSP_INIT : 64'h0;
        end else if (wrEn) begin
            if (dstE != RNONE) regFile[dstE] <= valE_w;
            if (dstM != RNONE) regFile[dstM] <= valM_w;
        end
    end

    // Read ports with optional same-cycle forwarding of the W-stage writes
    always_comb begin
        valA_d = 64'h0;
        valB_d = 64'h0;
        if (srcA != RNONE) begin
            if (BYPASS && srcA == w_dstM)      valA_d = valM_w;
            else if (BYPASS && srcA == w_dstE) valA_d = valE_w;
            else                               valA_d = regFile[srcA];
        end
        if (srcB != RNONE) begin
            if (BYPASS && srcB == w_dstM)      valB_d = valM_w;
            else if (BYPASS && srcB == w_dstE) valB_d = valE_w;
            else                               valB_d = regFile[srcB];
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Retired count: AOK instructions plus the halt instruction itself
    always_ff @(posedge clk) begin
        if (rst)
            retired <= 64'h0;
        else if (state == RUN && (w_stat == STAT_AOK || w_stat == STAT_HLT))
            retired <= retired + 64'd1;
    end
`else
    assign retired = 64'h0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus queues expected outputs for
// the current cycle, a monitor drains and compares them on the falling edge.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  icode_w, ifun_w, regA_w, regB_w, srcA, srcB;
    logic        cnd_w;
    logic [63:0] valE_w, valM_w;
    logic [2:0]  w_stat;
    logic [63:0] valA_d, valB_d, w_valE, w_valM, retired;
    logic [3:0]  w_dstE, w_dstM;
    logic [2:0]  cpu_stat;
    logic        halted;

    writeback_unit #(.BYPASS(1'b1), .RSP_INIT(64'h200)) dut (
        .clk(clk), .rst(rst),
        .icode_w(icode_w), .ifun_w(ifun_w), .cnd_w(cnd_w),
        .regA_w(regA_w), .regB_w(regB_w),
        .valE_w(valE_w), .valM_w(valM_w), .w_stat(w_stat),
        .srcA(srcA), .srcB(srcB),
        .valA_d(valA_d), .valB_d(valB_d),
        .w_dstE(w_dstE), .w_dstM(w_dstM),
        .w_valE(w_valE), .w_valM(w_valM),
        .cpu_stat(cpu_stat), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef enum int {S_VALA, S_VALB, S_DSTE, S_DSTM, S_STAT, S_HALT, S_RET, S_WVALE, S_WVALM} sel_t;
    typedef struct {
        string       name;
        sel_t        sel;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    int   nChecks = 0;
    int   nPass   = 0;

`ifdef WB_RETIRE_CNT_EN
    localparam logic [63:0] EXP_RET = 64'd4;
`else
    localparam logic [63:0] EXP_RET = 64'd0;
`endif

    task automatic expect_(input string name, input sel_t sel, input logic [63:0] v);
        exp_t e;
        e.name = name; e.sel = sel; e.exp = v;
        q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm,
                         input logic [2:0] st, input logic [3:0] sa, input logic [3:0] sb);
        icode_w = ic; ifun_w = 4'h0; cnd_w = c; regA_w = ra; regB_w = rb;
        valE_w = ve; valM_w = vm; w_stat = st; srcA = sa; srcB = sb;
    endtask

    task automatic bubble(input logic [3:0] sa, input logic [3:0] sb);
        drive(4'h1, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd0, sa, sb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every falling edge, compare all expectations queued this cycle
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [63:0] act;
            e = q.pop_front();
            case (e.sel)
                S_VALA:  act = valA_d;
                S_VALB:  act = valB_d;
                S_DSTE:  act = {60'h0, w_dstE};
                S_DSTM:  act = {60'h0, w_dstM};
                S_STAT:  act = {61'h0, cpu_stat};
                S_HALT:  act = {63'h0, halted};
                S_RET:   act = retired;
                S_WVALE: act = w_valE;
                default: act = w_valM;
            endcase
            nChecks++;
            if (act === e.exp) nPass++;
            else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
    end

    initial begin
        rst = 1'b1;
        bubble(4'hF, 4'hF);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // reset state
        bubble(4'h4, 4'h0);
        expect_("rst_rsp", S_VALA, 64'h200);
        expect_("rst_r0", S_VALB, 64'h0);
        expect_("rst_stat", S_STAT, 64'd1);
        expect_("rst_halt", S_HALT, 64'd0);
        expect_("rst_ret", S_RET, 64'd0);
        tick();

        // irmovq $0x55, %rdx
        drive(4'h3, 1'b0, 4'hF, 4'h2, 64'h55, 64'h0, 3'd1, 4'h2, 4'hF);
        expect_("irm_dstE", S_DSTE, 64'h2);
        expect_("irm_dstM", S_DSTM, 64'hF);
        expect_("irm_bypass", S_VALA, 64'h55);
        expect_("srcF_zero", S_VALB, 64'h0);
        expect_("irm_wvalE", S_WVALE, 64'h55);
        tick();
        bubble(4'h2, 4'h4);
        expect_("irm_array", S_VALA, 64'h55);
        expect_("rsp_kept", S_VALB, 64'h200);
        tick();

        // popq %rsp: M port wins
        drive(4'hB, 1'b0, 4'h4, 4'hF, 64'h208, 64'hAB, 3'd1, 4'h4, 4'h2);
        expect_("poprsp_dstE", S_DSTE, 64'h4);
        expect_("poprsp_dstM", S_DSTM, 64'h4);
        expect_("poprsp_byp", S_VALA, 64'hAB);
        expect_("poprsp_other", S_VALB, 64'h55);
        expect_("poprsp_wvalM", S_WVALM, 64'hAB);
        tick();
        bubble(4'h4, 4'hF);
        expect_("poprsp_array", S_VALA, 64'hAB);
        tick();

        // popq %rbx: rbx=valM, rsp=valE
        drive(4'hB, 1'b0, 4'h3, 4'hF, 64'hB0, 64'h77, 3'd1, 4'h3, 4'h4);
        expect_("poprbx_bypM", S_VALA, 64'h77);
        expect_("poprbx_bypE", S_VALB, 64'hB0);
        expect_("poprbx_dstM", S_DSTM, 64'h3);
        tick();
        bubble(4'h3, 4'h4);
        expect_("poprbx_rbx", S_VALA, 64'h77);
        expect_("poprbx_rsp", S_VALB, 64'hB0);
        tick();

        // cmovXX not taken, then taken
        drive(4'h2, 1'b0, 4'h1, 4'h6, 64'h99, 64'h0, 3'd1, 4'h6, 4'hF);
        expect_("cmov0_dstE", S_DSTE, 64'hF);
        expect_("cmov0_r6", S_VALA, 64'h0);
        tick();
        bubble(4'h6, 4'hF);
        expect_("cmov0_array", S_VALA, 64'h0);
        tick();
        drive(4'h2, 1'b1, 4'h1, 4'h6, 64'h99, 64'h0, 3'd1, 4'h6, 4'hF);
        expect_("cmov1_dstE", S_DSTE, 64'h6);
        tick();
        bubble(4'h6, 4'hF);
        expect_("cmov1_array", S_VALA, 64'h99);
        tick();

        // r1 = 0x11, then ADR on an OPq to r1
        drive(4'h3, 1'b0, 4'hF, 4'h1, 64'h11, 64'h0, 3'd1, 4'h1, 4'hF);
        tick();
        drive(4'h6, 1'b0, 4'h2, 4'h1, 64'h22, 64'h0, 3'd3, 4'h1, 4'hF);
        expect_("adr_dstE", S_DSTE, 64'hF);
        expect_("adr_nobyp", S_VALA, 64'h11);
        expect_("adr_prehalt", S_HALT, 64'd0);
        tick();
        drive(4'h3, 1'b0, 4'hF, 4'h1, 64'h33, 64'h0, 3'd1, 4'h1, 4'hF);
        expect_("adr_halted", S_HALT, 64'd1);
        expect_("adr_stat", S_STAT, 64'd3);
        expect_("halted_dstE", S_DSTE, 64'hF);
        expect_("halted_nobyp", S_VALA, 64'h11);
        tick();
        bubble(4'h1, 4'hF);
        expect_("halted_r1", S_VALA, 64'h11);
        tick();

        // reset overrides a same-cycle write
        rst = 1'b1;
        drive(4'h3, 1'b0, 4'hF, 4'h1, 64'h44, 64'h0, 3'd1, 4'hF, 4'hF);
        tick();
        rst = 1'b0;
        bubble(4'h1, 4'h4);
        expect_("rst2_r1", S_VALA, 64'h0);
        expect_("rst2_rsp", S_VALB, 64'h200);
        expect_("rst2_stat", S_STAT, 64'd1);
        expect_("rst2_halt", S_HALT, 64'd0);
        tick();

        // out-of-range status in RUN acts as INS; in HALTED it is ignored
        drive(4'h3, 1'b0, 4'hF, 4'h1, 64'h5A, 64'h0, 3'd7, 4'h1, 4'hF);
        expect_("st7_nobyp", S_VALA, 64'h0);
        tick();
        drive(4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd5, 4'h1, 4'hF);
        expect_("st7_stat", S_STAT, 64'd4);
        expect_("st7_halt", S_HALT, 64'd1);
        tick();
        bubble(4'h1, 4'hF);
        expect_("st5_ignored", S_STAT, 64'd4);
        expect_("st7_r1", S_VALA, 64'h0);
        tick();

        // retire sequence: 3 AOK, BUB, HLT, 2 AOK
        rst = 1'b1;
        bubble(4'hF, 4'hF);
        tick();
        rst = 1'b0;
        drive(4'h3, 1'b0, 4'hF, 4'h5, 64'h1, 64'h0, 3'd1, 4'hF, 4'hF); tick();
        drive(4'h3, 1'b0, 4'hF, 4'h5, 64'h2, 64'h0, 3'd1, 4'hF, 4'hF); tick();
        drive(4'h3, 1'b0, 4'hF, 4'h5, 64'h3, 64'h0, 3'd1, 4'hF, 4'hF); tick();
        bubble(4'hF, 4'hF); tick();
        drive(4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd2, 4'hF, 4'hF); tick();
        drive(4'h3, 1'b0, 4'hF, 4'h5, 64'h4, 64'h0, 3'd1, 4'hF, 4'hF); tick();
        drive(4'h3, 1'b0, 4'hF, 4'h5, 64'h5, 64'h0, 3'd1, 4'hF, 4'hF); tick();
        bubble(4'h5, 4'hF);
        expect_("ret_count", S_RET, EXP_RET);
        expect_("hlt_stat", S_STAT, 64'd2);
        expect_("hlt_halt", S_HALT, 64'd1);
        expect_("hlt_r5", S_VALA, 64'h3);
        tick();

        // let the monitor drain, bounded
        @(negedge clk);
        #1;
        nChecks++;
        if (q.size() == 0) nPass++;
        else $display("FAIL drain: got %0d pending expected 0", q.size());

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Consumer end of the memory→writeback pipeline register in the Y86-64 pipelined core.
- Takes the W-stage bundle, derives the destination registers, and owns the 15×64 register file with two write ports and two decode read ports.
- Runs the processor status FSM that stops architectural updates on halt or exception.
- Drives the W-stage forwarding signals back to decode.

Parameters:
- BYPASS, 1, 1: read ports return the data being written this cycle (write-before-read); 0: they return the stored value.
- RSP_INIT, 64'h0, reset value of %rsp (reg 4); all other registers reset to 0.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- icode_w  in  4  W-stage instruction code
- ifun_w  in  4  W-stage function code (unused except pass-through checks)
- cnd_w  in  1  condition result, used for cmovXX
- regA_w  in  4  rA field
- regB_w  in  4  rB field
- valE_w  in  64  ALU result
- valM_w  in  64  memory read data
- w_stat  in  3  status: 0 BUB, 1 AOK, 2 HLT, 3 ADR, 4 INS
- srcA  in  4  decode read address A
- srcB  in  4  decode read address B
- valA_d  out  64  read data A; 0 when srcA=4'hF
- valB_d  out  64  read data B; 0 when srcB=4'hF
- w_dstE  out  4  effective E destination (4'hF when suppressed)
- w_dstM  out  4  effective M destination (4'hF when suppressed)
- w_valE  out  64  equals valE_w
- w_valM  out  64  equals valM_w
- cpu_stat  out  3  architectural status
- halted  out  1  high in HALTED state
- retired  out  64  retired-instruction count (see Optional Feature)

Behaviour:
- dstE (combinational):
  - icode 2 with cnd_w=1, icode 3, icode 6 → regB_w
  - icode 8, 9, A, B → 4 (%rsp)
  - all other cases → F
- dstM (combinational): icode 5, B → regA_w; all other cases → F.
- Write enable: state RUN and w_stat==AOK. Otherwise w_dstE and w_dstM are driven to F and nothing is written.
- Writes take effect at posedge. E port writes valE_w to dstE; M port writes valM_w to dstM. dstE==dstM (e.g. popq %rsp): M wins and the register takes valM_w. Writes to F are ignored.
- Reads are combinational from the array.
  - BYPASS=1: if srcX equals an enabled w_dstM, return valM_w; else if it equals an enabled w_dstE, return valE_w; else return the array value.
  - BYPASS=0: return the array value only.
- FSM states: RUN, HALTED.
  - RUN: w_stat ∈ {HLT, ADR, INS} → HALTED, cpu_stat ← w_stat, that instruction writes nothing.
  - RUN: w_stat BUB → no write, no state change.
  - RUN: w_stat AOK → write, cpu_stat stays AOK.
  - HALTED: absorbing until rst; all writes suppressed; cpu_stat holds; out-of-range w_stat (5–7) ignored.
  - RUN: w_stat 5–7 treated as INS.
- Reset (synchronous, overrides same-cycle writes): all registers 0 except %rsp=RSP_INIT; state RUN; cpu_stat=1 (AOK); halted=0; retired=0.
- Reset asserted mid-run clears the HALTED state; no write from the reset cycle persists.
- Latency: a write is visible in the array one cycle after W-stage presentation, or same cycle via bypass.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: 64-bit counter `retired` increments by 1 on each cycle with state RUN and w_stat==AOK. It also increments on the cycle an HLT instruction is consumed (halt counts as retired); ADR and INS do not count. The counter wraps modulo 2^64 and is cleared by rst.
- Undefined: the counter logic is absent and `retired` is tied to 0.

Test Plan:
- Reset with RSP_INIT=64'h200 → read srcA=4 gives 64'h200; srcB=0 gives 0; cpu_stat=1; halted=0.
- irmovq (icode 3, regB=2, valE=64'h55, AOK) → w_dstE=2, w_dstM=F. With BYPASS=1, valA_d(srcA=2)=64'h55 in the same cycle; array holds 64'h55 next cycle.
- popq %rsp (icode B, regA=4, valE=64'h208, valM=64'hAB) → %rsp=64'hAB. Also popq %rbx (regA=3): %rbx=valM and %rsp=valE.
- cmovXX (icode 2, regB=6, cnd=0) → w_dstE=F and r6 unchanged; with cnd=1, r6=valE.
- w_stat=ADR carrying an OPq to r1 → r1 unchanged, halted=1, cpu_stat=3. Following AOK irmovq to r1 is ignored. rst → cpu_stat=1, r1=0.
- WB_RETIRE_CNT_EN defined: 3 AOK, 1 BUB, 1 HLT, then 2 AOK → retired=4, cpu_stat=2.
